// File: rtl/prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer_if
// Description : Host/core-facing signal bundle of the program sequencer.
//               master = host/testbench side, slave = sequencer side.
//   Start       host -> seq   level; begin or resume the program sequence
//   Done_in     core -> seq   level; current program finished
//   Init        seq  -> fetch load Start_PC into the fetch unit
//   Start_PC    seq  -> fetch start address of the current program
//   Prog_idx    seq  -> host  index of the current program
//   Running     seq  -> host  high while the program is executing
//   Cycle_count seq  -> host  run length of the last completed program
//   Count_valid seq  -> host  one-cycle pulse: Cycle_count/Timeout updated
//   Timeout     seq  -> host  last program was aborted by the watchdog
//   All_done    seq  -> host  every program in the table has finished
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_sequencer_if #(
    parameter int CW = 32
);
    logic          Start;
    logic          Done_in;
    logic          Init;
    logic [15:0]   Start_PC;
    logic [1:0]    Prog_idx;
    logic          Running;
    logic [CW-1:0] Cycle_count;
    logic          Count_valid;
    logic          Timeout;
    logic          All_done;

    modport master (
        output Start, Done_in,
        input  Init, Start_PC, Prog_idx, Running, Cycle_count,
               Count_valid, Timeout, All_done
    );

    modport slave (
        input  Start, Done_in,
        output Init, Start_PC, Prog_idx, Running, Cycle_count,
               Count_valid, Timeout, All_done
    );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : Run controller for the fetch unit and core. Walks a fixed
//               table of program start addresses; for each program it holds
//               Init for INIT_CYCLES cycles with the matching Start_PC,
//               counts run cycles until Done_in (or the watchdog fires) and
//               reports the count with a one-cycle Count_valid pulse.
// Ports       : CLK      - system clock, all state on posedge
//               Reset_n  - asynchronous active-low reset
//               bus      - prog_sequencer_if.slave (Start/Done_in in,
//                          Init/Start_PC/status/report out)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter int            NUM_PROGS    = 3,
    parameter logic [15:0]   PC0          = 16'd66,
    parameter logic [15:0]   PC1          = 16'd124,
    parameter logic [15:0]   PC2          = 16'd301,
    parameter logic [15:0]   PC3          = 16'd0,
    parameter int            INIT_CYCLES  = 2,
    parameter int            CW           = 32,
    parameter logic [CW-1:0] TIMEOUT      = CW'(1_000_000),
    parameter bit            AUTO_ADVANCE = 1'b1
) (
    input  wire logic        CLK,
    input  wire logic        Reset_n,
    prog_sequencer_if.slave  bus
);

    localparam int            c_IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [c_IW-1:0] c_INIT_LAST = c_IW'(INIT_CYCLES - 1);
    localparam logic [1:0]    c_LAST_IDX  = 2'(NUM_PROGS - 1);
    localparam logic [CW-1:0] c_CNT_MAX   = '1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SETUP    = 3'd1;  // restart from FINISHED: table[0] settles before Init
    localparam logic [2:0] c_LOAD     = 3'd2;
    localparam logic [2:0] c_RUN      = 3'd3;
    localparam logic [2:0] c_REPORT   = 3'd4;
    localparam logic [2:0] c_FINISHED = 3'd5;

    logic [2:0]      r_state;
    logic [1:0]      r_prog_idx;
    logic [15:0]     r_start_pc;
    logic [c_IW-1:0] r_init_cnt;
    logic [CW-1:0]   r_run_cnt;
    logic [CW-1:0]   r_cycle_count;
    logic            r_timeout;

    function automatic logic [15:0] f_pc(input logic [1:0] idx);
        case (idx)
            2'd0:    return PC0;
            2'd1:    return PC1;
            2'd2:    return PC2;
            default: return PC3;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= c_IDLE;
            r_prog_idx    <= 2'd0;
            r_start_pc    <= PC0;
            r_init_cnt    <= '0;
            r_run_cnt     <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.Start) r_state <= c_LOAD;
                end
                c_SETUP: begin
                    r_state <= c_LOAD;
                end
                // Done_in is deliberately ignored here: the previous
                // program's Done may still be asserted.
                c_LOAD: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_init_cnt <= '0;
                        r_run_cnt  <= CW'(1);
                        r_state    <= c_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                // Done takes priority over a watchdog expiry in the same cycle.
                c_RUN: begin
                    if (bus.Done_in) begin
                        r_cycle_count <= r_run_cnt;
                        r_timeout     <= 1'b0;
                        r_state       <= c_REPORT;
                    end else if (r_run_cnt == TIMEOUT) begin
                        r_cycle_count <= TIMEOUT;
                        r_timeout     <= 1'b1;
                        r_state       <= c_REPORT;
                    end else if (r_run_cnt != c_CNT_MAX) begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                // Start_PC is loaded together with the new index so it is
                // already correct in the first Init cycle of the next program.
                c_REPORT: begin
                    if (r_prog_idx == c_LAST_IDX) begin
                        r_state <= c_FINISHED;
                    end else begin
                        r_prog_idx <= r_prog_idx + 2'd1;
                        r_start_pc <= f_pc(r_prog_idx + 2'd1);
                        r_state    <= AUTO_ADVANCE ? c_LOAD : c_IDLE;
                    end
                end
                c_FINISHED: begin
                    if (bus.Start) begin
                        r_prog_idx <= 2'd0;
                        r_start_pc <= PC0;
                        r_timeout  <= 1'b0;
                        r_state    <= c_SETUP;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.Init        = (r_state == c_LOAD);
    assign bus.Running     = (r_state == c_RUN);
    assign bus.Count_valid = (r_state == c_REPORT);
    assign bus.All_done    = (r_state == c_FINISHED);
    assign bus.Start_PC    = r_start_pc;
    assign bus.Prog_idx    = r_prog_idx;
    assign bus.Cycle_count = r_cycle_count;
    assign bus.Timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Self-checking bench for prog_sequencer. One auto-advance and
//               one manual-advance instance (watchdog shortened to 20 cycles)
//               share a clock; a select bit routes bench stimulus to one of
//               them and muxes its outputs back to a common set of probes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;
    localparam int CW = 32;
    localparam int TO = 20;
    localparam int IC = 2;

    typedef struct {
        int lat;      // RUN cycle on which Done_in rises, 0 = never
        bit hold;     // keep Done_in high after the report
        int idx;
        int pc;
        int cnt;
        bit tmo;
        bit alldone;
    } vec_t;

    logic CLK = 1'b0;
    logic rst_n;
    logic sel;
    logic s_start;
    logic s_done;
    int   checks = 0;
    int   errors = 0;
    int   pcs [3] = '{66, 124, 301};

    always #5 CLK = ~CLK;

    prog_sequencer_if #(.CW(CW)) ifa ();
    prog_sequencer_if #(.CW(CW)) ifm ();

    assign ifa.Start   = s_start & ~sel;
    assign ifa.Done_in = s_done  & ~sel;
    assign ifm.Start   = s_start &  sel;
    assign ifm.Done_in = s_done  &  sel;

    logic          o_init, o_run, o_cv, o_to, o_ad;
    logic [15:0]   o_pc;
    logic [1:0]    o_idx;
    logic [CW-1:0] o_cnt;
    assign o_init = sel ? ifm.Init        : ifa.Init;
    assign o_run  = sel ? ifm.Running     : ifa.Running;
    assign o_cv   = sel ? ifm.Count_valid : ifa.Count_valid;
    assign o_to   = sel ? ifm.Timeout     : ifa.Timeout;
    assign o_ad   = sel ? ifm.All_done    : ifa.All_done;
    assign o_pc   = sel ? ifm.Start_PC    : ifa.Start_PC;
    assign o_idx  = sel ? ifm.Prog_idx    : ifa.Prog_idx;
    assign o_cnt  = sel ? ifm.Cycle_count : ifa.Cycle_count;

    prog_sequencer #(
        .NUM_PROGS(3), .PC0(16'd66), .PC1(16'd124), .PC2(16'd301), .PC3(16'd0),
        .INIT_CYCLES(IC), .CW(CW), .TIMEOUT(CW'(TO)), .AUTO_ADVANCE(1'b1)
    ) dut_a (
        .CLK(CLK), .Reset_n(rst_n), .bus(ifa)
    );

    prog_sequencer #(
        .NUM_PROGS(3), .PC0(16'd66), .PC1(16'd124), .PC2(16'd301), .PC3(16'd0),
        .INIT_CYCLES(IC), .CW(CW), .TIMEOUT(CW'(TO)), .AUTO_ADVANCE(1'b0)
    ) dut_m (
        .CLK(CLK), .Reset_n(rst_n), .bus(ifm)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Pulse Start for one cycle; from FINISHED a setup cycle precedes Init.
    task automatic pulse_start(input string tag, input bit from_fin);
        s_start = 1'b1;
        @(negedge CLK);
        s_start = 1'b0;
        if (from_fin) begin
            check({tag, " setup_no_init"}, o_init, 0);
            check({tag, " all_done_clr"}, o_ad, 0);
            check({tag, " idx_clr"}, o_idx, 0);
            check({tag, " pc_setup"}, o_pc, 66);
            check({tag, " timeout_clr"}, o_to, 0);
            @(negedge CLK);
        end
        check({tag, " start_latency"}, o_init, 1);
    endtask

    // Follow one program from Init to report and the cycle after it.
    task automatic run_prog(input string tag, input int lat, input bit hold, input int idx,
                            input int pc, input int cnt, input bit tmo, input bit alldone);
        int guard;
        int ic;
        int n;
        int nidx;
        bit spurious;
        guard = 0;
        while (o_init !== 1'b1 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check({tag, " init_rise"}, o_init, 1);
        check({tag, " start_pc"}, o_pc, pc);
        check({tag, " prog_idx"}, o_idx, idx);
        ic = 0;
        spurious = 1'b0;
        while (o_init === 1'b1 && ic < 20) begin
            if (o_cv !== 1'b0 || o_run !== 1'b0) spurious = 1'b1;
            ic++;
            @(negedge CLK);
        end
        check({tag, " init_len"}, ic, IC);
        check({tag, " quiet_in_load"}, spurious, 0);
        n = 0;
        guard = 0;
        while (o_cv !== 1'b1 && guard < TO + 20) begin
            if (o_run === 1'b1) n++;
            s_done = (lat != 0) && (hold ? (n >= lat) : (n == lat));
            @(negedge CLK);
            guard++;
        end
        check({tag, " report_seen"}, o_cv, 1);
        check({tag, " not_running"}, o_run, 0);
        check({tag, " cycle_count"}, o_cnt, cnt);
        check({tag, " timeout"}, o_to, tmo);
        if (!hold) s_done = 1'b0;
        @(negedge CLK);
        check({tag, " cv_pulse_len"}, o_cv, 0);
        check({tag, " count_hold"}, o_cnt, cnt);
        check({tag, " all_done"}, o_ad, alldone);
        nidx = alldone ? idx : idx + 1;
        check({tag, " next_idx"}, o_idx, nidx);
        check({tag, " next_pc"}, o_pc, pcs[nidx]);
    endtask

    initial begin
        vec_t vt [9];
        int   lat;
        int   idx;
        int   ecnt;
        bit   etmo;
        int   g;

        rst_n   = 1'b0;
        sel     = 1'b0;
        s_start = 1'b0;
        s_done  = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst init", o_init, 0);
        check("rst idx", o_idx, 0);
        check("rst pc", o_pc, 66);
        check("rst running", o_run, 0);
        check("rst count", o_cnt, 0);
        check("rst cv", o_cv, 0);
        check("rst timeout", o_to, 0);
        check("rst all_done", o_ad, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle no init", o_init, 0);

        //          lat hold idx  pc  cnt tmo ad
        vt[0] = '{10, 0, 0,  66, 10, 0, 0};
        vt[1] = '{ 7, 0, 1, 124,  7, 0, 0};
        vt[2] = '{ 9, 0, 2, 301,  9, 0, 1};
        vt[3] = '{ 5, 0, 0,  66,  5, 0, 0};
        vt[4] = '{ 7, 1, 1, 124,  7, 0, 0};
        vt[5] = '{ 1, 0, 2, 301,  1, 0, 1};
        vt[6] = '{ 0, 0, 0,  66, 20, 1, 0};
        vt[7] = '{20, 0, 1, 124, 20, 0, 0};
        vt[8] = '{ 0, 0, 2, 301, 20, 1, 1};
        for (int i = 0; i < 9; i++) begin
            if (vt[i].idx == 0) pulse_start($sformatf("vec%0d", i), i != 0);
            run_prog($sformatf("vec%0d", i), vt[i].lat, vt[i].hold, vt[i].idx,
                     vt[i].pc, vt[i].cnt, vt[i].tmo, vt[i].alldone);
        end

        // Random Done latencies against a watchdog-aware reference model.
        for (int k = 0; k < 6; k++) begin
            lat  = int'($urandom_range(0, TO + 4));
            idx  = k % 3;
            etmo = (lat == 0) || (lat > TO);
            ecnt = etmo ? TO : lat;
            if (idx == 0) pulse_start($sformatf("rnd%0d", k), 1'b1);
            run_prog($sformatf("rnd%0d", k), lat, 1'b0, idx, pcs[idx], ecnt, etmo, idx == 2);
        end

        // Asynchronous reset in the middle of program 1.
        pulse_start("arst", 1'b1);
        run_prog("arst_p0", 3, 1'b0, 0, 66, 3, 1'b0, 1'b0);
        g = 0;
        while (o_run !== 1'b1 && g < 20) begin
            @(negedge CLK);
            g++;
        end
        check("arst reached run", o_run, 1);
        repeat (3) @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        check("arst init", o_init, 0);
        check("arst idx", o_idx, 0);
        check("arst pc", o_pc, 66);
        check("arst running", o_run, 0);
        check("arst count", o_cnt, 0);
        check("arst cv", o_cv, 0);
        check("arst all_done", o_ad, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        check("arst idle", o_init, 0);
        pulse_start("arst_restart", 1'b0);
        run_prog("arst_rerun", 8, 1'b0, 0, 66, 8, 1'b0, 1'b0);

        // Manual-advance instance: waits in IDLE after each report.
        sel = 1'b1;
        @(negedge CLK);
        check("man idle", o_init, 0);
        pulse_start("man0", 1'b0);
        run_prog("man_p0", 4, 1'b0, 0, 66, 4, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            check("man wait0 init", o_init, 0);
        end
        check("man wait0 idx", o_idx, 1);
        pulse_start("man1", 1'b0);
        run_prog("man_p1", 0, 1'b0, 1, 124, 20, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            check("man wait1 init", o_init, 0);
        end
        pulse_start("man2", 1'b0);
        run_prog("man_p2", 6, 1'b0, 2, 301, 6, 1'b0, 1'b1);
        repeat (2) @(negedge CLK);
        check("man fin all_done", o_ad, 1);
        check("man fin idx", o_idx, 2);
        check("man fin init", o_init, 0);
        pulse_start("man_fin", 1'b1);
        run_prog("man_rerun", 2, 1'b0, 0, 66, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
